// File: rtl/w_input_conditioner.sv
// Synchronize and debounce the raw w switch and step button.
// Emits clean levels plus registered one-cycle edge pulses.
module w_input_conditioner_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit BOTH_EDGES      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  // bit 1 of the encoding is the debounced level itself
  typedef enum logic [1:0] {
    ST_LO  = 2'b00,
    CHK_HI = 2'b01,
    ST_HI  = 2'b11,
    CHK_LO = 2'b10
  } st_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  st_e                    st_q, st_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    st_d   = st_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      ST_LO: begin
        if (s) begin
          st_d  = CHK_HI;
          cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          st_d  = ST_LO;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = ST_HI;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (!s) begin
          st_d  = CHK_LO;
          cnt_d = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          st_d  = ST_HI;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d  = ST_LO;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = ST_LO;
        cnt_d = '0;
      end
    endcase
    pulse_d = ((st_q == CHK_HI) && (st_d == ST_HI)) ||
              (BOTH_EDGES && (st_q == CHK_LO) && (st_d == ST_LO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      st_q    <= ST_LO;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = st_q[1];
  assign pulse = pulse_q;

endmodule

module w_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic w_raw,
  input  logic step_raw,
  output logic w,
  output logic w_changed,
  output logic step,
  output logic step_level
);

  w_input_conditioner_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .BOTH_EDGES     (1'b1)
  ) u_w (
    .clk  (clk),
    .rst_n(reset),
    .raw  (w_raw),
    .level(w),
    .pulse(w_changed)
  );

  // press-only pulse: release never advances the FSM
  w_input_conditioner_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .BOTH_EDGES     (1'b0)
  ) u_step (
    .clk  (clk),
    .rst_n(reset),
    .raw  (step_raw),
    .level(step_level),
    .pulse(step)
  );

endmodule

// File: tb/tb_w_input_conditioner.sv
// Directed bench for w_input_conditioner.
// Small debounce count keeps every latency hand-checkable.
module tb_w_input_conditioner;

  logic clk;
  logic reset;
  logic w_raw;
  logic step_raw;
  logic w;
  logic w_changed;
  logic step;
  logic step_level;

  int checks = 0;
  int errors = 0;

  w_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .w_raw     (w_raw),
    .step_raw  (step_raw),
    .w         (w),
    .w_changed (w_changed),
    .step      (step),
    .step_level(step_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic ew,
                      input logic ewc, input logic est,
                      input logic esl);
    chk({tag, ".w"}, w, ew);
    chk({tag, ".w_changed"}, w_changed, ewc);
    chk({tag, ".step"}, step, est);
    chk({tag, ".step_level"}, step_level, esl);
  endtask

  // Raw change applied just before calling; outputs hold old
  // values for edges 1..6, switch on edge 7, pulses clear on 8.
  task automatic window(input string tag, input logic w0,
                        input logic sl0, input logic w1,
                        input logic wc7, input logic st7,
                        input logic sl1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk4($sformatf("%s.e%0d", tag, k), w0, 1'b0, 1'b0, sl0);
    end
    tick();
    chk4({tag, ".e7"}, w1, wc7, st7, sl1);
    tick();
    chk4({tag, ".e8"}, w1, 1'b0, 1'b0, sl1);
  endtask

  initial begin
    reset    = 1'b0;
    w_raw    = 1'b1;
    step_raw = 1'b1;
    #1;
    chk4("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk4($sformatf("rst.hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    reset = 1'b1;
    window("rst_rel", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    step_raw = 1'b0;
    window("rel1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    step_raw = 1'b1;
    window("press", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk4($sformatf("held%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
    end

    step_raw = 1'b0;
    window("rel2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    w_raw = 1'b0;
    window("wfall", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    w_raw = 1'b1; tick();
    chk4("bnc0", 1'b0, 1'b0, 1'b0, 1'b0);
    w_raw = 1'b0; tick();
    chk4("bnc1", 1'b0, 1'b0, 1'b0, 1'b0);
    w_raw = 1'b1; tick();
    chk4("bnc2", 1'b0, 1'b0, 1'b0, 1'b0);
    w_raw = 1'b0; tick();
    chk4("bnc3", 1'b0, 1'b0, 1'b0, 1'b0);
    w_raw = 1'b1;
    window("bnc_settle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    w_raw = 1'b0;
    window("wfall2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    w_raw = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    w_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk4($sformatf("glitch%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    step_raw = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk4($sformatf("mid.e%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk4($sformatf("mid.rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    window("mid_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    step_raw = 1'b0;
    window("rel3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    w_raw    = 1'b1;
    step_raw = 1'b1;
    window("simul", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
